// File: rtl/demux_1to8_deser_if.sv
// Bus between the scanned upstream 8:1 mux side and the serial-to-parallel collector.
// The master drives the serial beat; the slave returns the mux select and the collected word.
interface demux_1to8_deser_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic             start;
    logic             D_in;
    logic             D_valid;
    logic [SEL_W-1:0] Sel;
    logic [WIDTH-1:0] Y;
    logic             Y_valid;
    logic             busy;
    logic             abort;

    modport master (
        output start, D_in, D_valid,
        input  Sel, Y, Y_valid, busy, abort
    );

    modport slave (
        input  start, D_in, D_valid,
        output Sel, Y, Y_valid, busy, abort
    );
endinterface

// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel collector for a scanned 8:1 mux: fills slots 0..WIDTH-1 one bit per
// accepted beat, publishes the word with a one-cycle pulse and drives the upstream select.
module demux_1to8_deser #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input logic               clk,
    input logic               rst,
    demux_1to8_deser_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-2:0] shadow;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             busy;
    logic             abort;

    // The final slot goes straight into Y, so shadow only holds slots 0..WIDTH-2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            shadow  <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            abort   <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            abort   <= 1'b0;
            if (bus.D_valid) begin
                if (bus.start) begin
                    if (state == COLLECT && sel != '0) begin
                        abort <= 1'b1;
                    end
                    shadow <= {{(WIDTH-2){1'b0}}, bus.D_in};
                    sel    <= SLOT_ONE;
                    busy   <= 1'b1;
                    state  <= COLLECT;
                end else if (state == COLLECT) begin
                    if (sel == LAST_SLOT) begin
                        y       <= {bus.D_in, shadow};
                        y_valid <= 1'b1;
                        sel     <= '0;
                        busy    <= 1'b0;
                    end else begin
                        shadow[sel] <= bus.D_in;
                        sel         <= sel + SLOT_ONE;
                        busy        <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.Sel     = sel;
    assign bus.Y       = y;
    assign bus.Y_valid = y_valid;
    assign bus.busy    = busy;
    assign bus.abort   = abort;
endmodule

// File: tb/tb_demux_1to8_deser.sv
// Directed bench for demux_1to8_deser: hand-computed words, gaps, back-to-back, resync, reset.
module tb_demux_1to8_deser;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    demux_1to8_deser_if #(.WIDTH(8), .SEL_W(3)) bus ();

    demux_1to8_deser #(.WIDTH(8), .SEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic beat(input logic s, input logic v, input logic d);
        @(negedge clk);
        bus.start   = s;
        bus.D_valid = v;
        bus.D_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] w, input logic with_start,
                         input int gap2, input int gap6, input string tag);
        for (int k = 0; k < 8; k++) begin
            beat(with_start && k == 0, 1'b1, w[k]);
            if (k < 7) begin
                check({tag, "_noyv"}, bus.Y_valid, 0);
                check({tag, "_sel"}, bus.Sel, k + 1);
                check({tag, "_busy"}, bus.busy, 1);
            end else begin
                check({tag, "_yv"}, bus.Y_valid, 1);
                check({tag, "_y"}, bus.Y, w);
                check({tag, "_selwrap"}, bus.Sel, 0);
                check({tag, "_busy0"}, bus.busy, 0);
            end
            if (k == 1) begin
                for (int g = 0; g < gap2; g++) begin
                    beat(1'b0, 1'b0, 1'b1);
                    check({tag, "_gap_sel"}, bus.Sel, 2);
                    check({tag, "_gap_yv"}, bus.Y_valid, 0);
                end
            end
            if (k == 5) begin
                for (int g = 0; g < gap6; g++) begin
                    beat(1'b0, 1'b0, 1'b0);
                    check({tag, "_gap_sel"}, bus.Sel, 6);
                    check({tag, "_gap_yv"}, bus.Y_valid, 0);
                end
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        bus.start   = 1'b0;
        bus.D_valid = 1'b0;
        bus.D_in    = 1'b0;
        rst         = 1'b1;
        #1;
        check("rst_y", bus.Y, 0);
        check("rst_sel", bus.Sel, 0);
        check("rst_yv", bus.Y_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_abort", bus.abort, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // IDLE filtering
        for (int i = 0; i < 6; i++) begin
            beat(1'b0, i[0] == 1'b0, 1'b1);
            check("idle_sel", bus.Sel, 0);
            check("idle_y", bus.Y, 0);
            check("idle_yv", bus.Y_valid, 0);
            check("idle_busy", bus.busy, 0);
        end
        beat(1'b1, 1'b0, 1'b1);
        check("idle_startnov_sel", bus.Sel, 0);
        check("idle_startnov_busy", bus.busy, 0);

        frame(8'hA5, 1'b1, 0, 0, "single");
        beat(1'b0, 1'b0, 1'b0);
        check("single_pulse_end", bus.Y_valid, 0);
        check("single_y_hold", bus.Y, 8'hA5);

        frame(8'hA5, 1'b1, 3, 3, "gapped");

        frame(8'h3C, 1'b1, 0, 0, "b2b0");
        frame(8'hFF, 1'b0, 0, 0, "b2b1");

        // Resync after 5 beats of 0x00, then 0x81 starting on the resync beat
        for (int k = 0; k < 5; k++) beat(k == 0, 1'b1, 1'b0);
        check("pre_resync_sel", bus.Sel, 5);
        beat(1'b1, 1'b1, 1'b1);
        check("resync_abort", bus.abort, 1);
        check("resync_y", bus.Y, 8'hFF);
        check("resync_yv", bus.Y_valid, 0);
        check("resync_sel", bus.Sel, 1);
        for (int k = 1; k < 8; k++) begin
            beat(1'b0, 1'b1, (k == 7));
            if (k == 1) check("abort_pulse_end", bus.abort, 0);
        end
        check("resync_frame_yv", bus.Y_valid, 1);
        check("resync_frame_y", bus.Y, 8'h81);

        // start on the last slot resyncs rather than completing
        for (int k = 0; k < 7; k++) beat(k == 0, 1'b1, 1'b1);
        beat(1'b1, 1'b1, 1'b0);
        check("lastslot_abort", bus.abort, 1);
        check("lastslot_yv", bus.Y_valid, 0);
        check("lastslot_y", bus.Y, 8'h81);
        check("lastslot_sel", bus.Sel, 1);

        // start at Sel==0 in COLLECT is alignment, not abort
        for (int k = 1; k < 8; k++) beat(1'b0, 1'b1, 1'b0);
        check("align_pre_y", bus.Y, 8'h00);
        beat(1'b1, 1'b1, 1'b1);
        check("align_noabort", bus.abort, 0);
        check("align_sel", bus.Sel, 1);
        for (int k = 1; k < 8; k++) beat(1'b0, 1'b1, 1'b1);
        check("align_y", bus.Y, 8'hFF);

        // Reset mid-frame
        for (int k = 0; k < 4; k++) beat(k == 0, 1'b1, 1'b1);
        check("mid_sel", bus.Sel, 4);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_y", bus.Y, 0);
        check("midrst_sel", bus.Sel, 0);
        check("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.D_valid = 1'b0;
        frame(8'h5A, 1'b1, 0, 0, "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
